// File: rtl/pre_quant_scan_serializer_pkg.sv
// pre_quant_scan_serializer_pkg: shared encoder constants (block size, bank count, progressive scan table) and read FSM states
package pre_quant_scan_serializer_pkg;
  localparam int BLOCK_SIZE = 64;
  localparam int NUM_BANKS = 2;
  localparam logic [5:0] SCAN [BLOCK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  typedef enum logic {IDLE, STREAM} rd_state_e;
endpackage

// File: rtl/pre_quant_scan_serializer_scan_order_rom.sv
// scan_order_rom: combinational scan position to raster position lookup
// scan_idx_i: scan position 0..63, raster_idx_o: row*8+col of that position
module scan_order_rom
  import pre_quant_scan_serializer_pkg::*;
(
  input  logic [5:0] scan_idx_i,
  output logic [5:0] raster_idx_o
);
  assign raster_idx_o = SCAN[scan_idx_i];
endmodule

// File: rtl/pre_quant_scan_serializer.sv
// pre_quant_scan_serializer: ping-pong buffers 8x8 quantized blocks and streams them in progressive scan order
// CLOCK/RESET: clock, sync active-low reset; IN_VALID/IN_READY/INPUT_DATA: block input handshake;
// OUT_VALID/OUT_READY/OUT_DATA/OUT_INDEX/OUT_LAST: registered coefficient stream
module pre_quant_scan_serializer
  import pre_quant_scan_serializer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [31:0]       INPUT_DATA [8][8],
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [5:0]        OUT_INDEX,
  output logic              OUT_LAST
);
  logic [DATA_W-1:0] mem_q [NUM_BANKS][8][8];
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  rd_state_e state_q, state_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [5:0] out_index_q, out_index_d, nxt_idx, raster;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic accept, take, done, load;
  assign IN_READY = ~&full_q;
  assign accept = IN_VALID & IN_READY;
  assign take = out_valid_q & OUT_READY;
  assign done = take & out_last_q;
  // a new block always starts at scan position 0, otherwise advance within the current one
  assign nxt_idx = (state_q == STREAM && !done) ? out_index_q + 6'd1 : 6'd0;
  // rd_bank_d already points at the following bank when the last beat is taken
  assign load = (state_q == IDLE) ? full_q[rd_bank_d] : take & (~done | full_q[rd_bank_d]);
  scan_order_rom u_rom (
    .scan_idx_i  (nxt_idx),
    .raster_idx_o(raster)
  );
  always_comb begin
    full_d = full_q;
    wr_bank_d = accept ? ~wr_bank_q : wr_bank_q;
    rd_bank_d = done ? ~rd_bank_q : rd_bank_q;
    state_d = state_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
    out_index_d = out_index_q;
    out_data_d = out_data_q;
    if (accept) full_d[wr_bank_q] = 1'b1;
    if (done) full_d[rd_bank_q] = 1'b0;
    if (load) begin
      state_d = STREAM;
      out_valid_d = 1'b1;
      out_index_d = nxt_idx;
      out_last_d = &nxt_idx;
      out_data_d = mem_q[rd_bank_d][raster[5:3]][raster[2:0]];
    end else if (take) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      out_last_d = 1'b0;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= IDLE;
      full_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_index_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      full_q <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      out_index_q <= out_index_d;
      out_data_q <= out_data_d;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (accept)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          mem_q[wr_bank_q][r][c] <= INPUT_DATA[r][c][DATA_W-1:0];
  end
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST = out_last_q;
  assign OUT_INDEX = out_index_q;
  assign OUT_DATA = out_data_q;
endmodule

// File: tb/tb_pre_quant_scan_serializer.sv
// tb_pre_quant_scan_serializer: directed self-checking bench with scan-order scoreboard
module tb_pre_quant_scan_serializer;
  typedef struct {
    logic [31:0] d;
    logic [5:0]  i;
  } beat_t;
  logic CLOCK = 1'b0;
  logic RESET, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_LAST;
  logic [31:0] in_data [8][8];
  logic [31:0] OUT_DATA;
  logic [5:0] OUT_INDEX;
  int checks = 0;
  int failures = 0;
  int beats = 0;
  beat_t exp_q [$];
  logic stall_prev = 1'b0;
  logic [31:0] hold_d;
  logic [5:0] hold_i;
  logic hold_l;
  int scan_t [64] = '{0, 1, 8, 9, 2, 3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
                      4, 5, 12, 20, 13, 6, 7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
                      32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
                      51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  pre_quant_scan_serializer #(.DATA_W(32)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INPUT_DATA(in_data), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_INDEX(OUT_INDEX), .OUT_LAST(OUT_LAST)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int off);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_data[r][c] = 32'(r * 8 + c + off);
  endtask

  task automatic step();
    if (stall_prev) begin
      check("stall_data", 64'(OUT_DATA), 64'(hold_d));
      check("stall_index", 64'(OUT_INDEX), 64'(hold_i));
      check("stall_last", 64'(OUT_LAST), 64'(hold_l));
      check("stall_valid", 64'(OUT_VALID), 64'd1);
    end
    if (IN_VALID && IN_READY)
      for (int i = 0; i < 64; i++) begin
        beat_t b;
        int p;
        p = scan_t[i];
        b.d = in_data[p / 8][p % 8];
        b.i = 6'(i);
        exp_q.push_back(b);
      end
    if (OUT_VALID && OUT_READY) begin
      beats++;
      if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
      else begin
        beat_t b;
        b = exp_q.pop_front();
        check("data", 64'(OUT_DATA), 64'(b.d));
        check("index", 64'(OUT_INDEX), 64'(b.i));
        check("last", 64'(OUT_LAST), 64'(b.i == 6'd63));
      end
    end
    stall_prev = OUT_VALID && !OUT_READY;
    hold_d = OUT_DATA;
    hold_i = OUT_INDEX;
    hold_l = OUT_LAST;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      step();
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n, sent, bubbles, vcyc;
    logic acc;
    RESET = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    fill(0);
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_valid", 64'(OUT_VALID), 64'd0);
    check("rst_last", 64'(OUT_LAST), 64'd0);
    check("rst_data", 64'(OUT_DATA), 64'd0);
    check("rst_index", 64'(OUT_INDEX), 64'd0);
    check("rst_ready", 64'(IN_READY), 64'd1);
    RESET = 1'b1;
    step();
    // single block, raster-valued so the stream must reproduce the scan table
    fill(0);
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    beats = 0;
    step();
    IN_VALID = 1'b0;
    check("lat_acc_edge", 64'(OUT_VALID), 64'd0);
    step();
    check("lat_one_cycle", 64'(OUT_VALID), 64'd1);
    check("first_index", 64'(OUT_INDEX), 64'd0);
    check("first_data", 64'(OUT_DATA), 64'd0);
    drain();
    check("single_beats", 64'(beats), 64'd64);
    check("single_idle", 64'(OUT_VALID), 64'd0);
    // three back-to-back blocks
    fill(0);
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    sent = 0;
    beats = 0;
    bubbles = 0;
    n = 0;
    while ((sent < 3 || exp_q.size() > 0) && n < 1000) begin
      acc = IN_VALID && IN_READY;
      if (beats > 0 && exp_q.size() > 0 && !OUT_VALID) bubbles++;
      step();
      n++;
      if (acc) begin
        sent++;
        if (sent == 2) check("rdy_both_full", 64'(IN_READY), 64'd0);
        fill(sent * 100);
        if (sent == 3) IN_VALID = 1'b0;
      end
    end
    check("b2b_beats", 64'(beats), 64'd192);
    check("b2b_bubbles", 64'(bubbles), 64'd0);
    step();
    // OUT_READY toggling: first valid cycle sees a stall
    fill(7);
    IN_VALID = 1'b1;
    OUT_READY = 1'b0;
    beats = 0;
    vcyc = 0;
    n = 0;
    step();
    IN_VALID = 1'b0;
    while ((exp_q.size() > 0 || OUT_VALID) && n < 1000) begin
      OUT_READY = ~OUT_READY;
      if (OUT_VALID) vcyc++;
      step();
      n++;
    end
    check("toggle_beats", 64'(beats), 64'd64);
    check("toggle_cycles", 64'(vcyc), 64'd128);
    // downstream blocked with three blocks offered
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    beats = 0;
    fill(1000);
    step();
    fill(2000);
    step();
    check("blk_rdy_low", 64'(IN_READY), 64'd0);
    fill(3000);
    repeat (4) begin
      step();
      check("blk_rdy_hold", 64'(IN_READY), 64'd0);
    end
    OUT_READY = 1'b1;
    n = 0;
    while ((IN_VALID || exp_q.size() > 0) && n < 1000) begin
      acc = IN_VALID && IN_READY;
      step();
      n++;
      if (acc) IN_VALID = 1'b0;
    end
    check("blk_beats", 64'(beats), 64'd192);
    step();
    // reset in the middle of a block
    fill(300);
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    step();
    IN_VALID = 1'b0;
    n = 0;
    while (!(OUT_VALID && OUT_INDEX == 6'd20) && n < 100) begin
      step();
      n++;
    end
    check("beat20_reached", 64'(OUT_INDEX), 64'd20);
    RESET = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge CLOCK);
    #1;
    check("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    check("mid_rst_ready", 64'(IN_READY), 64'd1);
    check("mid_rst_index", 64'(OUT_INDEX), 64'd0);
    RESET = 1'b1;
    repeat (5) begin
      @(posedge CLOCK);
      #1;
      check("no_resume", 64'(OUT_VALID), 64'd0);
    end
    fill(400);
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    check("post_rst_index", 64'(OUT_INDEX), 64'd0);
    check("post_rst_data", 64'(OUT_DATA), 64'd400);
    drain();
    step();
    // extreme words pass through untouched
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_data[r][c] = 32'd0;
    in_data[0][0] = 32'hFFFF_FFFF;
    in_data[7][7] = 32'h8000_0000;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    check("max_word", 64'(OUT_DATA), 64'hFFFF_FFFF);
    n = 0;
    while (!OUT_LAST && n < 200) begin
      step();
      n++;
    end
    check("msb_index", 64'(OUT_INDEX), 64'd63);
    check("msb_word", 64'(OUT_DATA), 64'h8000_0000);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pre_quant_scan_serializer.md
PRE_QUANT_SCAN_SERIALIZER -- requirements
Module: pre_quant_scan_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the coefficient width.
REQ-002 The block SHALL have port CLOCK, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RESET, input, 1, reset that is synchronous and active-low (RESET==0 resets).
REQ-004 The block SHALL have port IN_VALID, input, 1, meaning a quantized 8x8 block is presented.
REQ-005 The block SHALL have port IN_READY, output, 1, meaning the block can be accepted this cycle.
REQ-006 The block SHALL have port INPUT_DATA, input, [31:0] [8][8], the quantized coefficients, [row][col].
REQ-007 The block SHALL have port OUT_VALID, output, 1, meaning OUT_DATA holds a valid coefficient.
REQ-008 The block SHALL have port OUT_READY, input, 1, meaning the downstream entropy coder takes the beat.
REQ-009 The block SHALL have port OUT_DATA, output, [DATA_W-1:0], the coefficient in scan order.
REQ-010 The block SHALL have port OUT_INDEX, output, [5:0], the scan position 0..63 of OUT_DATA.
REQ-011 The block SHALL have port OUT_LAST, output, 1, high when OUT_INDEX==63 with OUT_VALID high.

Function
REQ-012 A block SHALL be accepted on a rising edge where IN_VALID && IN_READY; all 64 words are captured in that edge into one of two banks.
REQ-013 Each bank SHALL carry a FULL flag; IN_READY SHALL be high iff at least one bank is not FULL, derived combinationally from registered flags.
REQ-014 The write side SHALL fill banks alternately (ping-pong); the read side SHALL drain banks in acceptance order.
REQ-015 The read FSM SHALL have states IDLE and STREAM; IDLE->STREAM when the read bank is FULL; STREAM->IDLE on the beat OUT_VALID && OUT_READY && OUT_LAST if the other bank is not FULL, otherwise it SHALL stay in STREAM on the other bank with index 0 next cycle (no bubble).
REQ-016 OUT_DATA, OUT_INDEX, OUT_VALID and OUT_LAST SHALL be registered; first OUT_VALID SHALL be asserted exactly 1 cycle after acceptance into an empty block.
REQ-017 OUT_DATA at scan position i SHALL equal INPUT_DATA[r][c] with r*8+c = SCAN[i], where SCAN = 0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27,4,5,12,20,13,6,7,14,21,28,29,22,15,23,30,31,32,33,40,48,41,34,35,42,49,56,57,50,43,36,37,44,51,58,59,52,45,38,39,46,53,60,61,54,47,55,62,63 (ProRes progressive scan).
REQ-018 OUT_DATA SHALL be the low DATA_W bits of the captured word, no rounding or saturation.
REQ-019 When OUT_VALID && !OUT_READY, all outputs SHALL hold unchanged (stall); the index SHALL advance only on a taken beat.
REQ-020 A bank's FULL flag SHALL clear on the edge taking its OUT_LAST beat; acceptance into that same bank on that same edge SHALL be permitted only if the other bank is also FULL-and-draining, i.e. IN_READY is not asserted early: simultaneous free and capture resolves as free-then-next-cycle-ready.
REQ-021 Sustained throughput SHALL be one coefficient per cycle with OUT_READY held high and IN_VALID held high (64 cycles per block).
REQ-022 With both banks FULL, IN_READY SHALL be 0 and INPUT_DATA SHALL be ignored.

Reset
REQ-023 While RESET==0 on an edge: both FULL flags 0, write/read bank pointers 0, FSM IDLE, index 0, OUT_VALID 0, OUT_LAST 0, OUT_DATA 0, OUT_INDEX 0; IN_READY consequently 1 the next cycle.
REQ-024 Reset mid-stream SHALL discard all buffered and partially emitted blocks; no beat SHALL resume after reset release.

Structure
REQ-025 The SCAN table, block size (64) and bank count (2) SHALL live in the shared encoder package as constants.
REQ-026 One sub-module, scan_order_rom (6-bit scan index in, 6-bit raster index out, combinational), SHALL be instantiated.

Verification
REQ-027 Single block INPUT_DATA[r][c]=r*8+c, OUT_READY=1 -> OUT_DATA sequence equals SCAN, OUT_VALID 1 cycle after accept, OUT_LAST at beat 64 only.
REQ-028 Back-to-back 3 blocks (values +0,+100,+200), IN_VALID=1, OUT_READY=1 -> 192 contiguous beats, no bubble, IN_READY low once both banks FULL.
REQ-029 OUT_READY toggled 1/0 each cycle -> outputs stable during every stall, sequence intact, 128 cycles per block.
REQ-030 OUT_READY=0 with 3 offered blocks -> first two accepted, IN_READY=0, third not captured; release -> blocks 1,2 then 3 in order.
REQ-031 RESET=0 asserted at beat 20 -> next cycle OUT_VALID=0, IN_READY=1; new block after release starts at OUT_INDEX 0.
REQ-032 INPUT_DATA with values 32'hFFFF_FFFF at [0][0] and 32'h8000_0000 at [7][7] -> emitted unchanged at OUT_INDEX 0 and 63.
